// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: fetch FSM encodings, reset/exception vectors and PC helpers.
package fetch_pc_unit_pkg;
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_ADDR  = 2'd1,
        FS_DATA  = 2'd2,
        FS_VALID = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC_GENERAL  = 32'hBFC0_0380;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// pc_next_sel: next-PC priority at a consume: live redirect, latched redirect, then sequential.
module pc_next_sel
    import fetch_pc_unit_pkg::*;
(
    input  logic        redir_req_i,
    input  logic [31:0] redir_tgt_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o
);
    assign next_pc_o = redir_req_i ? redir_tgt_i : redir_valid_i ? redir_pc_i : pc_plus4(pc_i);
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: MIPS fetch stage owning the PC, driving the inst_* SRAM-like port,
// preserving the branch delay slot and handling exception flushes.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        branch_taken_d,
    input  logic [31:0] branch_target_d,
    input  logic        jump_d,
    input  logic [31:0] jump_target_d,
    input  logic        flush_exc,
    input  logic [31:0] exc_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] inst_f,
    output logic        inst_valid_f
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, inst_q, inst_d, redir_pc_q, redir_pc_d, redir_tgt, next_pc;
    logic         redir_valid_q, redir_valid_d, discard_q, discard_d, redir_req;

    assign redir_req = !stall_f && (branch_taken_d || jump_d);
    assign redir_tgt = jump_d ? jump_target_d : branch_target_d;

    pc_next_sel u_pc_next_sel (
        .redir_req_i   (redir_req),
        .redir_tgt_i   (redir_tgt),
        .redir_valid_i (redir_valid_q),
        .redir_pc_i    (redir_pc_q),
        .pc_i          (pc_q),
        .next_pc_o     (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        discard_d     = discard_q;
        redir_valid_d = redir_valid_q || redir_req;
        redir_pc_d    = redir_req ? redir_tgt : redir_pc_q;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_ADDR;
                pc_d    = flush_exc ? exc_pc : pc_q;
            end
            FS_ADDR: begin
                if (flush_exc && !inst_addr_ok) begin
                    pc_d          = exc_pc;
                    redir_valid_d = 1'b0;
                end else if (inst_addr_ok) begin
                    state_d = FS_DATA;
                    if (flush_exc) begin
                        discard_d     = 1'b1;
                        redir_valid_d = 1'b1;
                        redir_pc_d    = exc_pc;
                    end
                end
            end
            FS_DATA: begin
                if (flush_exc) begin
                    discard_d     = 1'b1;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = exc_pc;
                end
                // A word returning for a flushed fetch is dropped and fetch restarts at the handler
                if (inst_data_ok && (discard_q || flush_exc)) begin
                    state_d       = FS_ADDR;
                    pc_d          = flush_exc ? exc_pc : redir_pc_q;
                    discard_d     = 1'b0;
                    redir_valid_d = redir_req && !flush_exc;
                    redir_pc_d    = redir_tgt;
                end else if (inst_data_ok) begin
                    state_d = FS_VALID;
                    inst_d  = inst_rdata;
                end
            end
            FS_VALID: begin
                if (flush_exc || !stall_f) begin
                    state_d       = FS_ADDR;
                    pc_d          = flush_exc ? exc_pc : next_pc;
                    redir_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            discard_q     <= discard_d;
        end
    end

    assign inst_req     = state_q == FS_ADDR;
    assign inst_addr    = pc_q;
    assign pc_f         = pc_q;
    assign inst_f       = inst_q;
    assign inst_valid_f = state_q == FS_VALID;
endmodule
